// File: rtl/configuration_pkg.sv
// System-wide sizing constants shared by the vector SRAM and HBM datapaths.
package configuration_pkg;
    localparam int VECTOR_SRAM_WIDTH      = 128;
    localparam int VECTOR_SRAM_DEPTH      = 1024;
    localparam int HBM_WIDTH              = 512;
    localparam int HBM_ADDR_WIDTH         = 128;
    localparam int HBM_V_Writeback_Amount = 4;
endpackage

// File: rtl/hbm_vector_writeback_pkg.sv
// Shared types and derived constants for the vector SRAM -> HBM writeback engine.
package hbm_vector_writeback_pkg;
    typedef enum logic [2:0] {
        WB_IDLE = 3'd0,
        WB_READ = 3'd1,
        WB_CAPT = 3'd2,
        WB_SEND = 3'd3,
        WB_DONE = 3'd4
    } hbm_wb_state_t;

    localparam int HBM_WB_ROWS_PER_BEAT = configuration_pkg::HBM_WIDTH / configuration_pkg::VECTOR_SRAM_WIDTH;
    localparam int HBM_BEAT_BYTES       = configuration_pkg::HBM_WIDTH / 8;

    // Counter width helper that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction
endpackage

// File: rtl/hbm_vector_writeback_packer.sv
// vec_beat_packer: gathers SRAM rows into one HBM beat, lowest row in the LSBs.
// With HBM_WB_STROBE_EN defined it also produces the byte strobe of the filled slots.
module vec_beat_packer
    import hbm_vector_writeback_pkg::*;
#(
    parameter int VEC_WIDTH = configuration_pkg::VECTOR_SRAM_WIDTH,
    parameter int HBM_WIDTH = configuration_pkg::HBM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   capt,
    input  logic [VEC_WIDTH-1:0]   row_data,
`ifdef HBM_WB_STROBE_EN
    output logic [HBM_WIDTH/8-1:0] beat_strb,
`endif
    output logic [HBM_WIDTH-1:0]   beat_data
);
    localparam int R  = HBM_WIDTH / VEC_WIDTH;
    localparam int CW = clog2_min1(R + 1);

    logic [HBM_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]        fill_q, fill_d;

    // Slot write: fill_q is both the count of captured rows and the next slot index.
    always_comb begin
        data_d = data_q;
        fill_d = fill_q;
        if (clear) begin
            data_d = '0;
            fill_d = '0;
        end else if (capt) begin
            for (int k = 0; k < R; k++) begin
                if (fill_q == CW'(k)) begin
                    data_d[k*VEC_WIDTH +: VEC_WIDTH] = row_data;
                end
            end
            fill_d = fill_q + 1'b1;
        end
    end

    // Slot storage and fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            fill_q <= '0;
        end else begin
            data_q <= data_d;
            fill_q <= fill_d;
        end
    end

    assign beat_data = data_q;

`ifdef HBM_WB_STROBE_EN
    // Strobe: every byte of each filled slot is set.
    always_comb begin
        beat_strb = '0;
        for (int k = 0; k < R; k++) begin
            beat_strb[k*(VEC_WIDTH/8) +: (VEC_WIDTH/8)] = (CW'(k) < fill_q) ? '1 : '0;
        end
    end
`endif
endmodule

// File: rtl/hbm_vector_writeback.sv
// hbm_vector_writeback: drains a run of vector SRAM rows to HBM as packed beats in bursts.
// Optional byte strobes on hbm_wr_strb when HBM_WB_STROBE_EN is defined.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
// once hbm_wr_valid is raised, the beat and its sidebands hold until that transfer.
module hbm_vector_writeback
    import hbm_vector_writeback_pkg::*;
#(
    parameter int VEC_WIDTH  = configuration_pkg::VECTOR_SRAM_WIDTH,
    parameter int HBM_WIDTH  = configuration_pkg::HBM_WIDTH,
    parameter int SRAM_DEPTH = configuration_pkg::VECTOR_SRAM_DEPTH,
    parameter int HBM_AW     = configuration_pkg::HBM_ADDR_WIDTH,
    parameter int WB_AMOUNT  = configuration_pkg::HBM_V_Writeback_Amount,
    parameter int CNT_W      = 16,
    parameter int SAW        = $clog2(SRAM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [SAW-1:0]         cmd_sram_addr,
    input  logic [HBM_AW-1:0]      cmd_hbm_addr,
    input  logic [CNT_W-1:0]       cmd_rows,
    output logic                   sram_rd_en,
    output logic [SAW-1:0]         sram_rd_addr,
    input  logic [VEC_WIDTH-1:0]   sram_rd_data,
    output logic                   hbm_wr_valid,
    input  logic                   hbm_wr_ready,
    output logic [HBM_AW-1:0]      hbm_wr_addr,
    output logic [HBM_WIDTH-1:0]   hbm_wr_data,
    output logic                   hbm_wr_last,
`ifdef HBM_WB_STROBE_EN
    output logic [HBM_WIDTH/8-1:0] hbm_wr_strb,
`endif
    output logic                   done
);
    localparam int R          = HBM_WIDTH / VEC_WIDTH;
    localparam int RCW        = clog2_min1(R + 1);
    localparam int BW         = clog2_min1(WB_AMOUNT);
    localparam int BEAT_BYTES = HBM_WIDTH / 8;

    hbm_wb_state_t     state_q, state_d;
    logic [SAW-1:0]    sram_addr_q, sram_addr_d;
    logic [HBM_AW-1:0] beat_addr_q, beat_addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [RCW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              capt_q, capt_d;
    logic              clear;
    logic              is_last;
    logic [HBM_WIDTH-1:0] packed_data;
`ifdef HBM_WB_STROBE_EN
    logic [HBM_WIDTH/8-1:0] packed_strb;
`endif

    // Next-state and control: one read per READ cycle, SRAM reads paused while a beat waits in SEND.
    always_comb begin
        state_d     = state_q;
        sram_addr_d = sram_addr_q;
        beat_addr_d = beat_addr_q;
        rem_d       = rem_q;
        rd_cnt_d    = rd_cnt_q;
        burst_d     = burst_q;
        cmd_ready   = 1'b0;
        sram_rd_en  = 1'b0;
        hbm_wr_valid = 1'b0;
        done        = 1'b0;
        clear       = 1'b0;
        is_last     = (burst_q == BW'(WB_AMOUNT - 1)) || (rem_q == '0);
        case (state_q)
            WB_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    sram_addr_d = cmd_sram_addr;
                    beat_addr_d = cmd_hbm_addr;
                    rem_d       = cmd_rows;
                    rd_cnt_d    = '0;
                    burst_d     = '0;
                    clear       = 1'b1;
                    state_d     = (cmd_rows == '0) ? WB_DONE : WB_READ;
                end
            end
            WB_READ: begin
                sram_rd_en  = 1'b1;
                sram_addr_d = (sram_addr_q == SAW'(SRAM_DEPTH - 1)) ? '0 : sram_addr_q + 1'b1;
                rem_d       = rem_q - 1'b1;
                rd_cnt_d    = rd_cnt_q + 1'b1;
                if (rd_cnt_q == RCW'(R - 1) || rem_q == CNT_W'(1)) begin
                    state_d = WB_CAPT;
                end
            end
            WB_CAPT: begin
                state_d = WB_SEND;
            end
            WB_SEND: begin
                hbm_wr_valid = 1'b1;
                if (hbm_wr_ready) begin
                    beat_addr_d = beat_addr_q + HBM_AW'(BEAT_BYTES);
                    burst_d     = is_last ? '0 : burst_q + 1'b1;
                    rd_cnt_d    = '0;
                    if (rem_q == '0) begin
                        state_d = WB_DONE;
                    end else begin
                        clear   = 1'b1;
                        state_d = WB_READ;
                    end
                end
            end
            WB_DONE: begin
                done    = 1'b1;
                state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Read data arrives one cycle after the strobe, so the capture enable is the delayed strobe.
    always_comb begin
        capt_d = sram_rd_en;
    end

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WB_IDLE;
            sram_addr_q <= '0;
            beat_addr_q <= '0;
            rem_q       <= '0;
            rd_cnt_q    <= '0;
            burst_q     <= '0;
            capt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sram_addr_q <= sram_addr_d;
            beat_addr_q <= beat_addr_d;
            rem_q       <= rem_d;
            rd_cnt_q    <= rd_cnt_d;
            burst_q     <= burst_d;
            capt_q      <= capt_d;
        end
    end

    vec_beat_packer #(
        .VEC_WIDTH (VEC_WIDTH),
        .HBM_WIDTH (HBM_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .capt      (capt_q),
        .row_data  (sram_rd_data),
`ifdef HBM_WB_STROBE_EN
        .beat_strb (packed_strb),
`endif
        .beat_data (packed_data)
    );

    // Output gating: beat fields read zero whenever no beat is offered.
    always_comb begin
        sram_rd_addr = sram_rd_en ? sram_addr_q : '0;
        hbm_wr_addr  = hbm_wr_valid ? beat_addr_q : '0;
        hbm_wr_data  = hbm_wr_valid ? packed_data : '0;
        hbm_wr_last  = hbm_wr_valid & is_last;
`ifdef HBM_WB_STROBE_EN
        hbm_wr_strb  = hbm_wr_valid ? packed_strb : '0;
`endif
    end
endmodule
